// File: rtl/gb_mapper_bridge_pkg.sv
// gb_mem_pkg: shared types, address regions and header decoding for the cartridge mapper bridge.
package gb_mem_pkg;
    typedef enum logic [2:0] {NONE, MBC1, MBC2, MBC3, MBC5} mbc_kind_e;
    typedef enum logic {IDLE, REQ} state_e;
    localparam logic [15:0] ROM_LO  = 16'h0000;
    localparam logic [15:0] ROM_HI  = 16'h7FFF;
    localparam logic [15:0] CRAM_LO = 16'hA000;
    localparam logic [15:0] CRAM_HI = 16'hBFFF;
    function automatic mbc_kind_e decode_mbc(input logic [7:0] b);
        return b == 8'h00 ? NONE :
               (b >= 8'h05 && b <= 8'h06) ? MBC2 :
               (b >= 8'h0F && b <= 8'h13) ? MBC3 :
               (b >= 8'h19 && b <= 8'h1E) ? MBC5 : MBC1;
    endfunction
endpackage

// File: rtl/gb_mapper_bridge_if.sv
// gb_mapper_bridge_if: request/acknowledge port toward the external memory arbiter.
interface gb_mapper_bridge_if #(parameter int MEM_AW = 24);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/gb_mapper_bridge_mbc_regs.sv
// gb_mbc_regs: unified MBC0/1/2/3/5 bank register file with ROM/RAM address translation.
import gb_mem_pkg::*;
module gb_mbc_regs #(
    parameter int ROM_AW = 23,
    parameter int RAM_AW = 17
) (
    input  logic              clock,
    input  logic              rst,
    input  mbc_kind_e         kind,
    input  logic [8:0]        rom_mask,
    input  logic              we,
    input  logic [14:0]       addr,
    input  logic [7:0]        din,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_enabled,
    output logic              ram_ok
);
    logic       ram_en, mode, en_val;
    logic [1:0] bank2, sel;
    logic [3:0] ram_bank, rbank;
    logic [8:0] rom_bank, lo_bank, hi_bank;

    assign sel    = addr[14:13];
    assign en_val = din[3:0] == 4'hA;

    // MBC1 keeps its 5-bit low bank in rom_bank[4:0] so one register serves every kind
    always_ff @(posedge clock) begin
        if (rst) begin
            ram_en   <= 1'b0;
            rom_bank <= 9'd1;
            ram_bank <= 4'd0;
            bank2    <= 2'd0;
            mode     <= 1'b0;
        end else if (we) begin
            case (kind)
                MBC1: case (sel)
                    2'd0:    ram_en   <= en_val;
                    2'd1:    rom_bank <= {4'd0, (din[4:0] == 5'd0 ? 5'd1 : din[4:0])};
                    2'd2:    bank2    <= din[1:0];
                    default: mode     <= din[0];
                endcase
                MBC2: if (!addr[14]) begin
                    if (addr[8]) rom_bank <= {5'd0, (din[3:0] == 4'd0 ? 4'd1 : din[3:0])};
                    else         ram_en   <= en_val;
                end
                MBC3: case (sel)
                    2'd0:    ram_en   <= en_val;
                    2'd1:    rom_bank <= {2'd0, (din[6:0] == 7'd0 ? 7'd1 : din[6:0])};
                    2'd2:    ram_bank <= din[3:0];
                    default: ;
                endcase
                MBC5: case (sel)
                    2'd0:    ram_en <= en_val;
                    2'd1:    if (addr[12]) rom_bank[8] <= din[0];
                             else          rom_bank[7:0] <= din;
                    2'd2:    ram_bank <= din[3:0];
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

    always_comb begin
        lo_bank     = (kind == MBC1 && mode) ? {2'd0, bank2, 5'd0} : 9'd0;
        hi_bank     = kind == MBC1 ? {2'd0, bank2, rom_bank[4:0]} : kind == NONE ? 9'd1 : rom_bank;
        rom_addr    = ROM_AW'({(addr[14] ? hi_bank : lo_bank) & rom_mask, addr[13:0]});
        rbank       = kind == MBC1 ? (mode ? {2'd0, bank2} : 4'd0) :
                      (kind == MBC3 || kind == MBC5) ? ram_bank : 4'd0;
        ram_addr    = RAM_AW'({rbank, (kind == MBC2 ? {4'd0, addr[8:0]} : addr[12:0])});
        ram_enabled = kind == NONE || ram_en;
        // MBC3 banks 08-0C select RTC registers, which this bridge does not implement
        ram_ok      = ram_enabled && !(kind == MBC3 && ram_bank >= 4'd8 && ram_bank <= 4'd12);
    end
endmodule

// File: rtl/gb_mapper_bridge.sv
// gb_mapper_bridge: maps CPU ROM/cart-RAM accesses onto the external memory request/ack port.
import gb_mem_pkg::*;
module gb_mapper_bridge #(
    parameter int                ROM_AW   = 23,
    parameter int                RAM_AW   = 17,
    parameter int                MEM_AW   = 24,
    parameter logic [MEM_AW-1:0] RAM_BASE = 24'h800000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        cfg_load,
    input  logic [7:0]  cfg_mbc_type,
    input  logic [7:0]  cfg_rom_size,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_we,
    output logic [7:0]  cpu_dout,
    output logic        cpu_busy,
    output logic        ram_enabled,
    gb_mapper_bridge_if.master bus
);
    localparam int BW = ROM_AW - 14;

    state_e            state, next;
    mbc_kind_e         kind;
    logic [8:0]        rom_mask, new_mask;
    logic [7:0]        rs_sat;
    logic              idle, rd, in_rom, in_cram, start, dead_rd, req_ram, ram_ok;
    logic [ROM_AW-1:0] rom_addr;
    logic [RAM_AW-1:0] ram_addr;

    assign idle     = state == IDLE;
    assign rd       = cpu_rd && !cpu_we;
    assign in_rom   = (cpu_addr & ~ROM_HI) == ROM_LO;
    assign in_cram  = cpu_addr >= CRAM_LO && cpu_addr <= CRAM_HI;
    assign start    = idle && ((in_rom && rd) || (in_cram && (rd || cpu_we) && ram_ok));
    assign dead_rd  = idle && in_cram && rd && !ram_ok;
    assign rs_sat   = cfg_rom_size > 8'(BW - 1) ? 8'(BW - 1) : cfg_rom_size;
    assign new_mask = 9'((10'd2 << rs_sat) - 10'd1);

    gb_mbc_regs #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) u_regs (
        .clock       (clock),
        .rst         (rst),
        .kind        (kind),
        .rom_mask    (rom_mask),
        .we          (idle && cpu_we && in_rom),
        .addr        (cpu_addr[14:0]),
        .din         (cpu_din),
        .rom_addr    (rom_addr),
        .ram_addr    (ram_addr),
        .ram_enabled (ram_enabled),
        .ram_ok      (ram_ok)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            kind          <= MBC1;
            rom_mask      <= 9'h1FF;
            cpu_dout      <= 8'hFF;
            req_ram       <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 8'h00;
        end else begin
            state <= next;
            if (cfg_load && idle) begin
                kind     <= decode_mbc(cfg_mbc_type);
                rom_mask <= new_mask;
            end
            if (start) begin
                req_ram       <= in_cram;
                bus.mem_we    <= cpu_we;
                bus.mem_addr  <= in_rom ? MEM_AW'(rom_addr) : (RAM_BASE | MEM_AW'(ram_addr));
                bus.mem_wdata <= cpu_din;
            end
            // MBC2 RAM is 4 bits wide; the upper nibble reads as ones
            if (dead_rd)
                cpu_dout <= 8'hFF;
            else if (!idle && bus.mem_ack && !bus.mem_we)
                cpu_dout <= (req_ram && kind == MBC2) ? {4'hF, bus.mem_rdata[3:0]} : bus.mem_rdata;
        end
    end

    always_comb begin
        next = idle ? (start ? REQ : IDLE) : (bus.mem_ack ? IDLE : REQ);
    end

    always_comb begin
        cpu_busy    = !idle;
        bus.mem_req = !idle;
    end
endmodule

// File: tb/tb_gb_mapper_bridge.sv
// tb_gb_mapper_bridge: randomized bench for gb_mapper_bridge against an arithmetic mapper model.
module tb_gb_mapper_bridge;
    logic        clock = 1'b0;
    logic        rst, cfg_load, cpu_rd, cpu_we, cpu_busy, ram_enabled;
    logic [7:0]  cfg_mbc_type, cfg_rom_size, cpu_din, cpu_dout;
    logic [15:0] cpu_addr;
    int vectors = 0, errors = 0;
    int m_kind, m_banks, m_ram_en, m_lo5, m_rom_bank, m_bank2, m_mode, m_ram_bank;

    gb_mapper_bridge_if #(.MEM_AW(24)) bus();

    gb_mapper_bridge dut (
        .clock(clock), .rst(rst), .cfg_load(cfg_load), .cfg_mbc_type(cfg_mbc_type),
        .cfg_rom_size(cfg_rom_size), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_rd(cpu_rd),
        .cpu_we(cpu_we), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy), .ram_enabled(ram_enabled),
        .bus(bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic int kind_of(input int t);
        return t == 0 ? 0 : (t == 5 || t == 6) ? 2 : (t >= 'h0F && t <= 'h13) ? 3 :
               (t >= 'h19 && t <= 'h1E) ? 5 : 1;
    endfunction

    function automatic int exp_rom(input int a);
        int bank;
        if (a < 'h4000) bank = (m_kind == 1 && m_mode == 1) ? m_bank2 * 32 : 0;
        else bank = m_kind == 1 ? m_bank2 * 32 + m_lo5 : m_kind == 0 ? 1 : m_rom_bank;
        return (bank % m_banks) * 16384 + a % 16384;
    endfunction

    function automatic int exp_ram(input int a);
        int rbank, off;
        rbank = m_kind == 1 ? (m_mode == 1 ? m_bank2 : 0) : (m_kind == 3 || m_kind == 5) ? m_ram_bank : 0;
        off = m_kind == 2 ? a % 512 : a % 8192;
        return 'h800000 + (rbank * 8192 + off) % 131072;
    endfunction

    function automatic bit model_ram_ok();
        return (m_kind == 0 || m_ram_en == 1) && !(m_kind == 3 && m_ram_bank >= 8 && m_ram_bank <= 12);
    endfunction

    function automatic void model_write(input int a, input int d);
        int region = a / 8192;
        if (a >= 'h8000) return;
        case (m_kind)
            1: begin
                if (region == 0) m_ram_en = d % 16 == 10;
                if (region == 1) m_lo5 = d % 32 == 0 ? 1 : d % 32;
                if (region == 2) m_bank2 = d % 4;
                if (region == 3) m_mode = d % 2;
            end
            2: if (a < 'h4000) begin
                if ((a / 256) % 2 == 1) m_rom_bank = d % 16 == 0 ? 1 : d % 16;
                else m_ram_en = d % 16 == 10;
            end
            3: begin
                if (region == 0) m_ram_en = d % 16 == 10;
                if (region == 1) m_rom_bank = d % 128 == 0 ? 1 : d % 128;
                if (region == 2) m_ram_bank = d % 16;
            end
            5: begin
                if (region == 0) m_ram_en = d % 16 == 10;
                if (region == 1 && a < 'h3000) m_rom_bank = (m_rom_bank / 256) * 256 + d;
                if (region == 1 && a >= 'h3000) m_rom_bank = m_rom_bank % 256 + (d % 2) * 256;
                if (region == 2) m_ram_bank = d % 16;
            end
            default: ;
        endcase
    endfunction

    task automatic apply_reset;
        rst = 1; cpu_rd = 0; cpu_we = 0; cfg_load = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        tick; tick;
        rst = 0;
        m_kind = 1; m_banks = 512; m_ram_en = 0; m_lo5 = 1; m_rom_bank = 1;
        m_bank2 = 0; m_mode = 0; m_ram_bank = 0;
    endtask

    task automatic configure(input logic [7:0] t, input logic [7:0] s);
        cfg_mbc_type = t; cfg_rom_size = s; cfg_load = 1;
        tick;
        cfg_load = 0;
        m_kind = kind_of(int'(t));
        m_banks = s >= 8 ? 512 : 2 << s;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        cpu_we = 1; cpu_rd = 0; cpu_addr = a; cpu_din = d;
        tick;
        cpu_we = 0;
        model_write(int'(a), int'(d));
    endtask

    task automatic access(input bit we, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] rdata, input int delay, output bit req,
                          output logic [23:0] addr, output bit mwe, output logic [7:0] wdata,
                          output int busy_n, output bit stable);
        cpu_we = we; cpu_rd = !we; cpu_addr = a; cpu_din = d;
        tick;
        cpu_we = 0; cpu_rd = 0;
        req = bus.mem_req; addr = bus.mem_addr; mwe = bus.mem_we; wdata = bus.mem_wdata;
        busy_n = cpu_busy ? 1 : 0; stable = 1;
        if (req) begin
            busy_n = 0;
            repeat (delay) begin
                if (cpu_busy) busy_n++;
                if (bus.mem_addr !== addr || bus.mem_req !== 1'b1 || bus.mem_wdata !== wdata) stable = 0;
                tick;
            end
            bus.mem_ack = 1; bus.mem_rdata = rdata;
            if (cpu_busy) busy_n++;
            tick;
            bus.mem_ack = 0;
            for (int i = 0; i < 50 && cpu_busy; i++) begin
                busy_n++;
                tick;
            end
        end
    endtask

    task automatic test_reset;
        bit req, mwe, st; logic [23:0] ad; logic [7:0] wd; int bn;
        apply_reset;
        vectors++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL reset_dout: got %h want FF", cpu_dout); end
        vectors++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", cpu_busy); end
        vectors++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
        vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
        vectors++; if (bus.mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
        vectors++; if (ram_enabled !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b want 0", ram_enabled); end
        access(0, 16'h0123, 8'h00, 8'h11, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h000123) begin errors++; $display("FAIL reset_rom0: got %h want 000123", ad); end
    endtask

    task automatic test_mbc1_basic;
        bit req, mwe, st; logic [23:0] ad; logic [7:0] wd; int bn;
        apply_reset;
        configure(8'h01, 8'h04);
        reg_write(16'h2000, 8'h00);
        access(0, 16'h4123, 8'h00, 8'h5A, 3, req, ad, mwe, wd, bn, st);
        vectors++; if (req !== 1'b1) begin errors++; $display("FAIL mbc1_req: got %b want 1", req); end
        vectors++; if (ad !== 24'h004123) begin errors++; $display("FAIL mbc1_addr: got %h want 004123", ad); end
        vectors++; if (mwe !== 1'b0) begin errors++; $display("FAIL mbc1_we: got %b want 0", mwe); end
        vectors++; if (bn != 4) begin errors++; $display("FAIL mbc1_busy_cycles: got %0d want 4", bn); end
        vectors++; if (st !== 1'b1) begin errors++; $display("FAIL mbc1_stable: got %b want 1", st); end
        vectors++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL mbc1_dout: got %h want 5A", cpu_dout); end
    endtask

    task automatic test_mbc1_mode;
        bit req, mwe, st; logic [23:0] ad; logic [7:0] wd; int bn;
        apply_reset;
        configure(8'h01, 8'h06);
        reg_write(16'h6000, 8'h01);
        reg_write(16'h4000, 8'h03);
        reg_write(16'h2000, 8'h00);
        access(0, 16'h0000, 8'h00, 8'h01, 1, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h180000) begin errors++; $display("FAIL mode1_low: got %h want 180000", ad); end
        access(0, 16'h4000, 8'h00, 8'h02, 1, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h184000) begin errors++; $display("FAIL mode1_high: got %h want 184000", ad); end
        reg_write(16'h0000, 8'h0A);
        vectors++; if (ram_enabled !== 1'b1) begin errors++; $display("FAIL mode1_ram_en: got %b want 1", ram_enabled); end
        access(0, 16'hA000, 8'h00, 8'h03, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h806000) begin errors++; $display("FAIL mode1_ram: got %h want 806000", ad); end
    endtask

    task automatic test_mbc5;
        bit req, mwe, st; logic [23:0] ad; logic [7:0] wd; int bn;
        apply_reset;
        configure(8'h19, 8'h08);
        reg_write(16'h2000, 8'hFF);
        reg_write(16'h3000, 8'h01);
        access(0, 16'h7FFF, 8'h00, 8'h44, 2, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h7FFFFF) begin errors++; $display("FAIL mbc5_top: got %h want 7FFFFF", ad); end
        reg_write(16'h2000, 8'h00);
        reg_write(16'h3000, 8'h00);
        access(0, 16'h4000, 8'h00, 8'h45, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h000000) begin errors++; $display("FAIL mbc5_bank0: got %h want 000000", ad); end
    endtask

    task automatic test_mbc3;
        bit req, mwe, st; logic [23:0] ad; logic [7:0] wd; int bn;
        apply_reset;
        configure(8'h13, 8'h05);
        access(0, 16'h0010, 8'h00, 8'h12, 0, req, ad, mwe, wd, bn, st);
        access(0, 16'hA000, 8'h00, 8'h99, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (req !== 1'b0) begin errors++; $display("FAIL mbc3_dis_req: got %b want 0", req); end
        vectors++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL mbc3_dis_dout: got %h want FF", cpu_dout); end
        vectors++; if (bn != 0) begin errors++; $display("FAIL mbc3_dis_busy: got %0d want 0", bn); end
        reg_write(16'h0000, 8'h0A);
        reg_write(16'h4000, 8'h02);
        access(1, 16'hA010, 8'h77, 8'h00, 1, req, ad, mwe, wd, bn, st);
        vectors++; if (mwe !== 1'b1) begin errors++; $display("FAIL mbc3_wr_we: got %b want 1", mwe); end
        vectors++; if (ad !== 24'h804010) begin errors++; $display("FAIL mbc3_wr_addr: got %h want 804010", ad); end
        vectors++; if (wd !== 8'h77) begin errors++; $display("FAIL mbc3_wr_data: got %h want 77", wd); end
        reg_write(16'h4000, 8'h08);
        access(1, 16'hA000, 8'h55, 8'h00, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (req !== 1'b0) begin errors++; $display("FAIL mbc3_rtc_wr: got %b want 0", req); end
        access(0, 16'h0020, 8'h00, 8'h34, 0, req, ad, mwe, wd, bn, st);
        access(0, 16'hA000, 8'h00, 8'h66, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (req !== 1'b0 || cpu_dout !== 8'hFF) begin errors++; $display("FAIL mbc3_rtc_rd: got req %b dout %h want 0 FF", req, cpu_dout); end
    endtask

    task automatic test_mbc2;
        bit req, mwe, st; logic [23:0] ad; logic [7:0] wd; int bn;
        apply_reset;
        configure(8'h05, 8'h03);
        reg_write(16'h0100, 8'h03);
        access(0, 16'h4000, 8'h00, 8'h21, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h00C000) begin errors++; $display("FAIL mbc2_rom: got %h want 00C000", ad); end
        reg_write(16'h0000, 8'h0A);
        vectors++; if (ram_enabled !== 1'b1) begin errors++; $display("FAIL mbc2_ram_en: got %b want 1", ram_enabled); end
        access(0, 16'hA1FF, 8'h00, 8'h35, 1, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h8001FF) begin errors++; $display("FAIL mbc2_ram_addr: got %h want 8001FF", ad); end
        vectors++; if (cpu_dout !== 8'hF5) begin errors++; $display("FAIL mbc2_nibble: got %h want F5", cpu_dout); end
    endtask

    task automatic test_misc;
        bit req, mwe, st; logic [23:0] ad; logic [7:0] wd; int bn;
        apply_reset;
        configure(8'h01, 8'h04);
        access(0, 16'h0100, 8'h00, 8'h3C, 0, req, ad, mwe, wd, bn, st);
        access(0, 16'hC000, 8'h00, 8'h77, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (req !== 1'b0 || cpu_dout !== 8'h3C) begin errors++; $display("FAIL outside: got req %b dout %h want 0 3C", req, cpu_dout); end
        cpu_rd = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_din = 8'h05;
        tick;
        cpu_rd = 0; cpu_we = 0;
        model_write('h2000, 5);
        vectors++; if (bus.mem_req !== 1'b0 || cpu_busy !== 1'b0) begin errors++; $display("FAIL rd_we_both: got req %b busy %b want 0 0", bus.mem_req, cpu_busy); end
        cpu_rd = 1; cpu_addr = 16'h4000;
        tick;
        cpu_rd = 0;
        cfg_mbc_type = 8'h01; cfg_rom_size = 8'h00; cfg_load = 1;
        tick;
        cfg_load = 0; bus.mem_ack = 1;
        tick;
        bus.mem_ack = 0;
        access(0, 16'h4000, 8'h00, 8'h10, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'(exp_rom('h4000))) begin errors++; $display("FAIL cfg_busy: got %h want %h", ad, exp_rom('h4000)); end
        configure(8'h00, 8'h00);
        vectors++; if (ram_enabled !== 1'b1) begin errors++; $display("FAIL none_ram_en: got %b want 1", ram_enabled); end
    endtask

    task automatic test_reset_mid;
        bit req, mwe, st; logic [23:0] ad; logic [7:0] wd; int bn;
        apply_reset;
        configure(8'h19, 8'h08);
        reg_write(16'h2000, 8'h07);
        cpu_rd = 1; cpu_addr = 16'h4000;
        tick;
        cpu_rd = 0;
        vectors++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", bus.mem_req); end
        rst = 1;
        tick;
        rst = 0;
        vectors++; if (bus.mem_req !== 1'b0 || cpu_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got req %b busy %b want 0 0", bus.mem_req, cpu_busy); end
        bus.mem_ack = 1; bus.mem_rdata = 8'hAB;
        tick;
        bus.mem_ack = 0;
        vectors++; if (cpu_busy !== 1'b0 || bus.mem_req !== 1'b0 || cpu_dout !== 8'hFF) begin errors++; $display("FAIL rstmid_late_ack: got busy %b req %b dout %h want 0 0 FF", cpu_busy, bus.mem_req, cpu_dout); end
        m_kind = 1; m_banks = 512; m_ram_en = 0; m_lo5 = 1; m_rom_bank = 1; m_bank2 = 0; m_mode = 0; m_ram_bank = 0;
        access(0, 16'h4000, 8'h00, 8'h01, 0, req, ad, mwe, wd, bn, st);
        vectors++; if (ad !== 24'h004000) begin errors++; $display("FAIL rstmid_bank: got %h want 004000", ad); end
    endtask

    task automatic test_random(input logic [7:0] t, input logic [7:0] s, input int n);
        bit req, mwe, st, is_ram, ok; logic [23:0] ad; logic [7:0] wd, rdata, want; int bn, a, delay;
        apply_reset;
        configure(t, s);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 'h7FFF);
                reg_write(16'(a), $urandom_range(0, 3) == 0 ? 8'h0A : 8'($urandom));
            end else begin
                is_ram = $urandom_range(0, 1) == 1;
                a = is_ram ? $urandom_range('hA000, 'hBFFF) : $urandom_range(0, 'h7FFF);
                rdata = 8'($urandom);
                delay = $urandom_range(0, 3);
                ok = !is_ram || model_ram_ok();
                access(0, 16'(a), 8'h00, rdata, delay, req, ad, mwe, wd, bn, st);
                vectors++; if (req !== ok) begin errors++; $display("FAIL rnd_req t=%h a=%h: got %b want %b", t, a, req, ok); end
                if (ok && !(is_ram && m_kind == 0)) begin
                    vectors++; if (ad !== 24'(is_ram ? exp_ram(a) : exp_rom(a))) begin errors++; $display("FAIL rnd_addr t=%h a=%h: got %h want %h", t, a, ad, is_ram ? exp_ram(a) : exp_rom(a)); end
                end
                if (ok) begin
                    vectors++; if (bn != delay + 1) begin errors++; $display("FAIL rnd_busy t=%h: got %0d want %0d", t, bn, delay + 1); end
                end
                if (!(m_kind == 2 && !is_ram)) begin
                    want = !ok ? 8'hFF : (is_ram && m_kind == 2) ? {4'hF, rdata[3:0]} : rdata;
                    vectors++; if (cpu_dout !== want) begin errors++; $display("FAIL rnd_dout t=%h a=%h: got %h want %h", t, a, cpu_dout, want); end
                end
            end
        end
    endtask

    initial begin
        rst = 1; cfg_load = 0; cfg_mbc_type = 0; cfg_rom_size = 0; cpu_addr = 0; cpu_din = 0;
        cpu_rd = 0; cpu_we = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        test_reset;
        test_mbc1_basic;
        test_mbc1_mode;
        test_mbc5;
        test_mbc3;
        test_mbc2;
        test_misc;
        test_reset_mid;
        test_random(8'h01, 8'h05, 60);
        test_random(8'h05, 8'h03, 60);
        test_random(8'h13, 8'h06, 60);
        test_random(8'h1B, 8'h08, 60);
        test_random(8'h00, 8'h01, 40);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/gb_mapper_bridge.md
Name: gb_mapper_bridge

Overview:
Parametrised cartridge mapper and external-memory bridge for the Game Boy core. It replaces the per-MBC on-chip-RAM mux with a single unified bank register file covering MBC0/1/2/3/5. It translates CPU accesses to 0000-7FFF (ROM) and A000-BFFF (cart RAM) into request/acknowledge transactions on a shared external memory port (SDRAM/PSRAM controller). It sits between the CPU bus decoder and the memory arbiter; WRAM, boot ROM and I/O remain outside this block.

Parameters:
ROM_AW, 23, ROM byte-address width (8 MB max, 512 banks).
RAM_AW, 17, cart RAM byte-address width (128 KB max, 16 banks).
MEM_AW, 24, external memory address width.
RAM_BASE, 24'h800000, external base address of the cart RAM window.

Ports:
clock  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_load  in  1  one-cycle pulse; latches cfg_mbc_type and cfg_rom_size
cfg_mbc_type  in  8  cartridge header byte 0x147
cfg_rom_size  in  8  cartridge header byte 0x148
cpu_addr  in  16  CPU address
cpu_din  in  8  CPU write data
cpu_rd  in  1  one-cycle read strobe
cpu_we  in  1  one-cycle write strobe
cpu_dout  out  8  read data, valid when cpu_busy is low after a read
cpu_busy  out  1  transaction in flight; CPU stalls
ram_enabled  out  1  cart RAM enable state
mem_req  out  1  external request, held until ack
mem_we  out  1  request is a write
mem_addr  out  MEM_AW  external byte address
mem_wdata  out  8  external write data
mem_ack  in  1  one-cycle completion pulse from the arbiter
mem_rdata  in  8  read data, valid with mem_ack

Behaviour:
- Reset values:
  - cpu_dout=FF, cpu_busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ram_enabled=0, rom_bank=1, ram_bank=0, bank2=0, mbc1_mode=0, kind=MBC1.
- Config:
  - On cfg_load, the latched kind is decoded as: 00 NONE; 01-03 MBC1; 05-06 MBC2; 0F-13 MBC3; 19-1E MBC5; anything else MBC1.
  - rom_mask = (2<<cfg_rom_size)-1, saturated to ROM_AW-14 bits.
  - cfg_load is ignored while cpu_busy=1.
- Region match: ROM is 0000-7FFF; cart RAM is A000-BFFF. Strobes outside these regions are ignored, and cpu_dout holds its value.
- Register writes (cpu_we in ROM region):
  - Take effect at the next edge. They generate no mem_req and never assert cpu_busy.
  - MBC1:
    - 0000-1FFF: ram_en = din[3:0]==A.
    - 2000-3FFF: lo5 = din[4:0], with 0 mapped to 1.
    - 4000-5FFF: bank2 = din[1:0].
    - 6000-7FFF: mode = din[0].
  - MBC2 (0000-3FFF only; A8 selects the register):
    - A8=0: ram_en = din[3:0]==A.
    - A8=1: rom_bank = din[3:0], with 0 mapped to 1.
  - MBC3:
    - 0000-1FFF: ram_en.
    - 2000-3FFF: rom_bank = din[6:0], with 0 mapped to 1.
    - 4000-5FFF: ram_bank = din[3:0]. Values 08-0C (RTC) make RAM reads return FF and RAM writes get dropped.
  - MBC5:
    - 0000-1FFF: ram_en.
    - 2000-2FFF: rom_bank[7:0].
    - 3000-3FFF: rom_bank[8] = din[0]. Bank 0 is legal.
    - 4000-5FFF: ram_bank = din[3:0].
  - NONE: all register writes are ignored, and RAM is always enabled.
- ROM address computation:
  - Effective bank for 0000-3FFF: MBC1 with mode=1 gives {bank2,5'b0}; otherwise 0.
  - Effective bank for 4000-7FFF:
    - MBC1: {bank2, lo5}.
    - NONE: 1.
    - Other kinds: rom_bank.
  - Address = ({bank & rom_mask, addr[13:0]}) truncated to ROM_AW, then zero-extended.
- RAM address computation:
  - Address = RAM_BASE | ({rbank, addr[12:0]} truncated to RAM_AW).
  - rbank: MBC1 uses mode ? bank2 : 0; MBC3/5 use ram_bank; MBC2 uses 0 with addr[8:0] only.
- Transaction FSM:
  - IDLE: a ROM cpu_rd, or a RAM cpu_rd/cpu_we with RAM enabled, moves to REQ at the next edge. At that edge cpu_busy=1, mem_req=1, mem_addr/mem_we/mem_wdata are registered, and they stay stable until ack.
  - REQ: on mem_ack, go to IDLE at the next edge with mem_req=0 and cpu_busy=0. For a read, cpu_dout = mem_rdata; MBC2 forces cpu_dout[7:4] = F.
  - Minimum latency: strobe at cycle 0, mem_req high at cycle 1; if ack arrives at cycle 1, cpu_busy falls at cycle 2.
- Disabled or RTC-selected RAM:
  - A read sets cpu_dout=FF at the next edge, with no request and no busy.
  - A write is dropped.
- Strobes during REQ are ignored; this is a CPU contract violation and needs no recovery.
- mem_ack in IDLE is ignored, including a late ack after reset.
- Simultaneous cpu_rd and cpu_we: the write wins.
- rst mid-transaction: mem_req and cpu_busy are 0 after the edge, all registers are at reset values, and the FSM is in IDLE.

Decomposition:
- gb_mem_pkg holds:
  - mbc_kind_e {NONE, MBC1, MBC2, MBC3, MBC5};
  - region constants ROM_LO/ROM_HI/CRAM_LO/CRAM_HI;
  - function decode_mbc(byte) -> mbc_kind_e;
  - state enum {IDLE, REQ}.
- Sub-module gb_mbc_regs: the bank register file plus combinational ROM/RAM address and ram_en computation. The top level holds the config latch, region match and transaction FSM.

Test Plan:
- MBC1 config, rom_size=04 (32 banks); write 2000=00 then read 4123; ack after 3 cycles with rdata=5A -> mem_addr=004123; cpu_busy is high for exactly 4 cycles; cpu_dout=5A.
- MBC5, rom_size=08; write 2000=FF, 3000=01, then read 7FFF -> mem_addr=7FFFFF. Then write 2000=00, 3000=00 and read 4000 -> mem_addr=000000 (bank 0 is legal).
- MBC3; read A000 with RAM disabled -> no mem_req, cpu_dout=FF next cycle. Then write 0000=0A, 4000=02, and write A010=77 -> mem_we=1, mem_addr=804010, mem_wdata=77.
- MBC2; write 0100=03, read 4000 -> mem_addr=00C000. Enable RAM, read A1FF with rdata=35 -> cpu_dout=F5.
- Assert rst while mem_req=1, then pulse mem_ack one cycle after reset -> mem_req=0, cpu_busy=0, rom_bank=1, no cpu_dout update.
- MBC1 mode=1, bank2=3, rom_size=06; read 0000 -> mem_addr=180000; read 4000 with lo5=0 -> mem_addr=184000 (the 0->1 rule applies).
